// File: rtl/parity_frame_tx.sv
// UART-style frame transmitter: start, 8 data bits LSB first, parity, stop.
// Each bit is held on tx for CLKS_PER_BIT clocks; parity is computed at accept.
//
// state  | meaning
// IDLE   | tx high, waiting for in_valid && in_ready
// START  | start bit (0) on tx
// DATA   | data bit bit_idx on tx, LSB first
// PARITY | latched parity bit on tx
// STOP   | stop bit (1) on tx
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              even_odd,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              parity_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;

    logic accept;
    logic bit_done;

    assign accept   = in_valid && rdy_q;
    assign bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        rdy_d     = rdy_q;

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (bit_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // in_ready comes up one edge after reset release and stays up until accept
                rdy_d = 1'b1;
                tx_d  = 1'b1;
                if (accept) begin
                    shift_d   = data_in;
                    parity_d  = (^data_in) ^ ~even_odd;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    rdy_d     = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'(DATA_W - 1)) begin
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d   = ST_IDLE;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                    rdy_d     = 1'b1;
                    bit_idx_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                rdy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
        end
    end

    assign in_ready   = rdy_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign parity_out = parity_q;

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

- Serial framing stage directly downstream of the parity generator.
- Accepts a byte and an even/odd select over a valid/ready handshake and computes the parity bit for that byte internally.
- Shifts out a UART-style frame on a single line: start bit, 8 data bits LSB first, parity bit, stop bit.
- Each bit is held for a programmable number of clock cycles.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles each frame bit is held on tx; legal range 1..65535.
- DATA_W, default 8: data width; only 8 is supported.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled only on accept.
- even_odd  input  1  parity select, sampled on accept; 1 = even parity, 0 = odd parity.
- in_valid  input  1  data_in/even_odd valid.
- in_ready  output  1  block can accept; high only in IDLE with rst low.
- tx  output  1  serial line; idle high.
- busy  output  1  frame in progress, from the accept edge to the end of the stop bit.
- parity_out  output  1  parity bit of the current or last frame.

## Operation
- Accept when in_valid && in_ready at a rising clk edge. On accept:
  - latch data_in into the shift register;
  - compute and latch parity = (^data_in) ^ ~even_odd, so the total count of ones including parity is even for even_odd=1 and odd for even_odd=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY after 8 bits × CLKS_PER_BIT cycles.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- tx value by state: IDLE 1, START 0, DATA current shift-register bit 0 (LSB first), PARITY latched parity, STOP 1. tx is driven from a register; no glitches.
- Counters:
  - Bit-period counter, width ceil(log2(CLKS_PER_BIT)) (minimum 1), counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit-index counter, 3 bits, 0..7 in DATA.
- Inputs are ignored while busy. data_in/even_odd changes mid-frame have no effect.
- Reset (async, any state, including mid-frame):
  - FSM -> IDLE; tx=1, busy=0, parity_out=0, in_ready=0 while rst high; all counters 0.
  - A partial frame is abandoned, not completed.
- in_ready rises in the first cycle after rst deasserts.

## Timing
- Define the accept edge as E and C = CLKS_PER_BIT.
- After E: busy=1, in_ready=0, tx=0.
- Data bit i (0..7) is driven on tx from edge E+(1+i)·C through E+(2+i)·C.
- Parity is driven from E+9C; stop bit from E+10C.
- At edge E+11C: FSM returns to IDLE, busy=0, in_ready=1, tx stays 1.
- Frame length is exactly 11·C cycles.
- Back-to-back operation: if in_valid is held high, the next accept is at edge E+11C+1. This gives a minimum of one IDLE cycle (tx=1) between frames. Throughput is one byte per 11C+1 cycles.
- parity_out is updated at the accept edge and held until the next accept or reset.
- Latency from accept to first tx transition (start bit) is 0 cycles after E, i.e. registered output, 1 clock.

## Test plan
- Reset: assert rst mid-cycle with clk running -> tx=1, busy=0, in_ready=0, parity_out=0 immediately; one cycle after release, in_ready=1.
- data_in=8'h03, even_odd=1, C=4 -> tx sequence per 4-cycle bit: 0,1,1,0,0,0,0,0,0, parity 0, stop 1; busy high for exactly 44 cycles; parity_out=0.
- data_in=8'h03, even_odd=0 -> same data bits, parity bit 1; data_in=8'hFF, even_odd=0 -> parity 1; data_in=8'h00, even_odd=1 -> parity 0.
- Back-to-back: in_valid held high with 8'hA5 then 8'h5A -> second start bit begins exactly 45 cycles after the first accept (C=4), with one idle-high cycle between frames; both frames bit-exact.
- Mid-frame input change: toggle data_in/even_odd during DATA of 8'h81 -> transmitted frame and parity_out unaffected; in_ready stays 0 until frame end.
- Reset mid-frame: assert rst during the DATA bit 3 period -> tx returns to 1 asynchronously, no parity/stop emitted; a new accept after release transmits a full clean 11-bit frame.
